// File: rtl/boot_pkg.sv
// Shared state encoding and default widths for the instruction-memory boot sequencer.
package boot_pkg;
  localparam int DEFAULT_DATA_WIDTH    = 32;
  localparam int DEFAULT_ADDR_WIDTH    = 8;
  localparam int DEFAULT_RELEASE_DELAY = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FLUSH = 3'd2,
    RUN   = 3'd3,
    ERROR = 3'd4
  } state_t;
endpackage

// File: rtl/imem_boot_sequencer_release_timer.sv
// Down-counter that holds the core in reset for DELAY cycles after the final write.
// expire is high in the last counted cycle so the sequencer leaves FLUSH on time.
module release_timer #(
  parameter int DELAY = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expire
);
  localparam int CW = $clog2(DELAY + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(DELAY);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign expire = (cnt == CW'(1));
endmodule

// File: rtl/imem_boot_sequencer.sv
// Streams a boot image into instruction memory, then releases the core reset.
// Optional checksum of the loaded image is enabled by defining BOOT_CHECKSUM_EN.
module imem_boot_sequencer
  import boot_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH    = DEFAULT_ADDR_WIDTH,
  parameter int RELEASE_DELAY = DEFAULT_RELEASE_DELAY
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  ld_valid,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  ld_last,
  output logic                  ld_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic                  core_reset_n,
  output logic                  busy,
  output logic                  done,
  output logic                  err_overflow,
  output logic [ADDR_WIDTH:0]   word_count,
  output state_t                state
`ifdef BOOT_CHECKSUM_EN
  ,
  input  logic [DATA_WIDTH-1:0] chk_expected,
  output logic                  chk_ok
`endif
);
  // Handshake: a word transfers on a rising edge where ld_valid and ld_ready are both 1;
  // ld_ready is high only in LOAD and ld_data/ld_last must be stable while ld_valid is high.
  logic accept;
  logic last_idx;
  logic chk_pass;
  logic restart;
  logic timer_load;
  logic timer_expire;

  assign accept   = ld_valid & ld_ready;
  assign last_idx = (word_count[ADDR_WIDTH-1:0] == {ADDR_WIDTH{1'b1}});
  assign restart  = start & ((state == IDLE) | (state == RUN) | (state == ERROR));

`ifdef BOOT_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] chk_acc;
  logic [DATA_WIDTH-1:0] chk_next;

  assign chk_next = chk_acc ^ ld_data;
  assign chk_pass = (chk_next == chk_expected);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chk_acc <= '0;
      chk_ok  <= 1'b0;
    end else if (restart) begin
      chk_acc <= '0;
      chk_ok  <= 1'b0;
    end else if (accept) begin
      chk_acc <= chk_next;
      if (ld_last && chk_pass) chk_ok <= 1'b1;
    end
  end
`else
  assign chk_pass = 1'b1;
`endif

  assign timer_load = accept & ld_last & chk_pass;

  release_timer #(
    .DELAY(RELEASE_DELAY)
  ) u_release_timer (
    .clk   (clk),
    .rst   (reset),
    .load  (timer_load),
    .expire(timer_expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      ld_ready     <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      core_reset_n <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err_overflow <= 1'b0;
      word_count   <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        IDLE, RUN, ERROR: begin
          if (start) begin
            state        <= LOAD;
            ld_ready     <= 1'b1;
            busy         <= 1'b1;
            done         <= 1'b0;
            core_reset_n <= 1'b0;
            err_overflow <= 1'b0;
            word_count   <= '0;
          end
        end
        LOAD: begin
          if (accept) begin
            imem_we    <= 1'b1;
            imem_addr  <= word_count[ADDR_WIDTH-1:0];
            imem_wdata <= ld_data;
            word_count <= word_count + (ADDR_WIDTH+1)'(1);
            // The last-word marker wins over overflow at the top address.
            if (ld_last) begin
              ld_ready <= 1'b0;
              if (chk_pass) begin
                state <= FLUSH;
              end else begin
                state <= ERROR;
                busy  <= 1'b0;
              end
            end else if (last_idx) begin
              state        <= ERROR;
              ld_ready     <= 1'b0;
              busy         <= 1'b0;
              err_overflow <= 1'b1;
            end
          end
        end
        FLUSH: begin
          if (timer_expire) begin
            state        <= RUN;
            busy         <= 1'b0;
            done         <= 1'b1;
            core_reset_n <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          ld_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_imem_boot_sequencer.sv
// Scoreboard bench for imem_boot_sequencer: expected writes are queued by the driver
// and popped by a write monitor; control outputs are checked at fixed cycle points.
module tb_imem_boot_sequencer;
  import boot_pkg::*;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int RD = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_last;
  logic          ld_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_wdata;
  logic          core_reset_n;
  logic          busy;
  logic          done;
  logic          err_overflow;
  logic [AW:0]   word_count;
  state_t        state;
`ifdef BOOT_CHECKSUM_EN
  logic [DW-1:0] chk_expected;
  logic          chk_ok;
`endif

  int checks = 0;
  int errors = 0;
  logic [AW+DW-1:0] exp_q[$];
  logic [AW-1:0]    exp_addr;

  imem_boot_sequencer #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .RELEASE_DELAY(RD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ld_valid    (ld_valid),
    .ld_data     (ld_data),
    .ld_last     (ld_last),
    .ld_ready    (ld_ready),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .core_reset_n(core_reset_n),
    .busy        (busy),
    .done        (done),
    .err_overflow(err_overflow),
    .word_count  (word_count),
    .state       (state)
`ifdef BOOT_CHECKSUM_EN
    ,
    .chk_expected(chk_expected),
    .chk_ok      (chk_ok)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    errors++;
    $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // write monitor / scoreboard
  logic [AW+DW-1:0] mon_exp;
  always @(negedge clk) begin
    if (!reset && imem_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write at %0t",
                 imem_addr, imem_wdata, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        check("imem_write", {imem_addr, imem_wdata}, mon_exp);
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_addr = '0;
  endtask

  task automatic send_word(input logic [DW-1:0] data, input logic last);
    ld_valid = 1'b1;
    ld_data  = data;
    ld_last  = last;
    exp_q.push_back({exp_addr, data});
    exp_addr = exp_addr + 1'b1;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic wait_run(input int budget);
    int n = 0;
    while (!core_reset_n && n < budget) begin
      tick();
      n++;
    end
    check("run_reached", core_reset_n, 1'b1);
  endtask

  logic [DW-1:0] tbl [4];

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    ld_valid = 1'b0;
    ld_data  = '0;
    ld_last  = 1'b0;
    exp_addr = '0;
`ifdef BOOT_CHECKSUM_EN
    chk_expected = '0;
`endif
    tbl[0] = 32'h1111_0001;
    tbl[1] = 32'h2222_0002;
    tbl[2] = 32'h3333_0003;
    tbl[3] = 32'h4444_0004;

    // reset state
    tick();
    tick();
    check("rst_core_reset_n", core_reset_n, 1'b0);
    check("rst_ld_ready", ld_ready, 1'b0);
    check("rst_word_count", word_count, 0);
    check("rst_imem_we", imem_we, 1'b0);
    reset = 1'b0;
    tick();
    check("idle_state", state, IDLE);
    check("idle_busy", busy, 1'b0);

    // three-word image, release four cycles after the final write
    pulse_start();
    check("load_ready", ld_ready, 1'b1);
    check("load_busy", busy, 1'b1);
    send_word(32'h2008_0005, 1'b0);
    send_word(32'h2009_0007, 1'b0);
    send_word(32'h0109_5020, 1'b1);
    for (int i = 0; i < RD; i++) begin
      check("flush_core_reset_n", core_reset_n, 1'b0);
      tick();
    end
    check("run_core_reset_n", core_reset_n, 1'b1);
    check("run_done", done, 1'b1);
    check("run_word_count", word_count, 3);
    check("run_busy", busy, 1'b0);

    // restart from RUN, toggled valid, stall, start ignored during FLUSH
    pulse_start();
    check("restart_core_reset_n", core_reset_n, 1'b0);
    check("restart_done", done, 1'b0);
    check("restart_word_count", word_count, 0);
    for (int i = 0; i < 4; i++) begin
      send_word(tbl[i], i == 3);
      if (i == 1) begin
        ld_data = 32'hDEAD_BEEF;
        tick();
        tick();
        tick();
        check("stall_word_count", word_count, 2);
      end
      if (i != 3) begin
        ld_data = 32'hDEAD_BEEF;
        tick();
      end
    end
    check("flush_state", state, FLUSH);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("flush_start_busy", busy, 1'b1);
    check("flush_start_count", word_count, 4);
    tick();
    tick();
    check("flush_late_core_reset_n", core_reset_n, 1'b0);
    tick();
    check("toggle_run_core_reset_n", core_reset_n, 1'b1);

    // ld_valid in RUN has no effect
    ld_valid = 1'b1;
    ld_data  = 32'hCAFE_F00D;
    tick();
    tick();
    tick();
    check("run_valid_ready", ld_ready, 1'b0);
    check("run_valid_count", word_count, 4);
    ld_valid = 1'b0;

    // overflow: 256 words without a last marker
    pulse_start();
    for (int i = 0; i < 256; i++) begin
      send_word({8'(i), 8'(~i), 16'h0BEE}, 1'b0);
    end
    check("ovf_state", state, ERROR);
    check("ovf_err", err_overflow, 1'b1);
    check("ovf_core_reset_n", core_reset_n, 1'b0);
    check("ovf_word_count", word_count, 256);
    check("ovf_ld_ready", ld_ready, 1'b0);
    ld_valid = 1'b1;
    tick();
    tick();
    ld_valid = 1'b0;
    check("ovf_queue_empty", exp_q.size(), 0);
    pulse_start();
    check("err_restart_err", err_overflow, 1'b0);
    check("err_restart_count", word_count, 0);

    // reset in the middle of a load
    send_word(32'hAAAA_0000, 1'b0);
    send_word(32'hAAAA_0001, 1'b0);
    tick();
    check("mid_word_count", word_count, 2);
    ld_valid = 1'b1;
    ld_data  = 32'hBAD0_BAD0;
    #2;
    reset = 1'b1;
    #1;
    check("async_ld_ready", ld_ready, 1'b0);
    check("async_word_count", word_count, 0);
    check("async_imem_addr", imem_addr, 0);
    check("async_state", state, IDLE);
    check("async_busy", busy, 1'b0);
    ld_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("after_reset_queue", exp_q.size(), 0);
    pulse_start();
    send_word(32'h5555_0000, 1'b0);
    send_word(32'h5555_0001, 1'b1);
    wait_run(10);
    check("reload_word_count", word_count, 2);

`ifdef BOOT_CHECKSUM_EN
    // checksum match then mismatch
    chk_expected = 32'h7;
    pulse_start();
    check("chk_cleared", chk_ok, 1'b0);
    send_word(32'h1, 1'b0);
    send_word(32'h2, 1'b0);
    send_word(32'h4, 1'b1);
    check("chk_match_ok", chk_ok, 1'b1);
    check("chk_match_state", state, FLUSH);
    wait_run(10);
    check("chk_match_hold", chk_ok, 1'b1);
    chk_expected = 32'h6;
    pulse_start();
    check("chk_restart_ok", chk_ok, 1'b0);
    send_word(32'h1, 1'b0);
    send_word(32'h2, 1'b0);
    send_word(32'h4, 1'b1);
    check("chk_bad_state", state, ERROR);
    check("chk_bad_ok", chk_ok, 1'b0);
    check("chk_bad_err", err_overflow, 1'b0);
    for (int i = 0; i < 6; i++) tick();
    check("chk_bad_core_reset_n", core_reset_n, 1'b0);
`endif

    tick();
    check("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/imem_boot_sequencer.md
IMEM_BOOT_SEQUENCER -- requirements
Module: imem_boot_sequencer

Interface
REQ-001 SHALL take parameter DATA_WIDTH, default 32, meaning the load word and instruction-memory data width.
REQ-002 SHALL take parameter ADDR_WIDTH, default 8, meaning the word-address width of the instruction memory (256 words).
REQ-003 SHALL take parameter RELEASE_DELAY, default 4, meaning the number of cycles between the last write and core reset release.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous active-high reset.
REQ-006 SHALL have port start, input, 1 bit: single-cycle pulse that begins a load.
REQ-007 SHALL have ports ld_valid (input, 1), ld_data (input, DATA_WIDTH), ld_last (input, 1) and ld_ready (output, 1): the load-stream handshake.
REQ-008 SHALL have ports imem_we (output, 1), imem_addr (output, ADDR_WIDTH) and imem_wdata (output, DATA_WIDTH): the instruction-memory write port.
REQ-009 SHALL have port core_reset_n, output, 1 bit: active-low reset driven to the MIPS core.
REQ-010 SHALL have ports busy (output, 1), done (output, 1), err_overflow (output, 1) and word_count (output, ADDR_WIDTH+1).

Function
REQ-011 SHALL implement the states IDLE, LOAD, FLUSH, RUN and ERROR.
REQ-012 IDLE SHALL move to LOAD when start=1, clear word_count and hold core_reset_n=0.
REQ-013 ld_ready SHALL be 1 only in LOAD; a word is accepted in a cycle where ld_valid=1 and ld_ready=1.
REQ-014 An accepted word SHALL produce imem_we=1, imem_addr=word_count (pre-increment) and imem_wdata=ld_data in the next cycle, which gives a registered 1-cycle latency; imem_we SHALL be 0 in all other cycles.
REQ-015 word_count SHALL increment by 1 per accepted word.
REQ-016 An accepted word with ld_last=1 SHALL move the block LOAD->FLUSH.
REQ-017 An accepted word at index 2^ADDR_WIDTH-1 with ld_last=0 SHALL still be written and SHALL move the block LOAD->ERROR with err_overflow=1.
REQ-018 FLUSH SHALL last exactly RELEASE_DELAY cycles and then move to RUN.
REQ-019 In RUN, core_reset_n SHALL be 1 and done SHALL be 1.
REQ-020 core_reset_n SHALL be 0 in every state other than RUN.
REQ-021 busy SHALL be 1 in LOAD and FLUSH.
REQ-022 start in LOAD or FLUSH SHALL be ignored.
REQ-023 start in RUN or ERROR SHALL re-enter LOAD: core_reset_n=0, done=0, err_overflow=0 and word_count=0 in the next cycle.
REQ-024 ld_valid outside LOAD SHALL have no effect.
REQ-025 ld_valid=0 in LOAD SHALL stall with no write and no count change.

Reset
REQ-026 While reset=1, the block SHALL immediately and asynchronously enter IDLE with outputs ld_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_reset_n=0, busy=0, done=0, err_overflow=0 and word_count=0.
REQ-027 A reset during LOAD SHALL abandon the load; no pending write SHALL be issued after reset.

Configuration
REQ-028 The macro BOOT_CHECKSUM_EN SHALL add input chk_expected (DATA_WIDTH) and output chk_ok (1), and SHALL maintain an XOR of all accepted words.
REQ-029 With BOOT_CHECKSUM_EN defined, on the ld_last word a mismatch between the running XOR and chk_expected SHALL move the block to ERROR (err_overflow=0, chk_ok=0) instead of FLUSH; a match SHALL set chk_ok=1 until the next start or reset.
REQ-030 With BOOT_CHECKSUM_EN undefined, the chk_expected and chk_ok ports and the checksum logic SHALL be absent and behaviour SHALL be as in REQ-016.

Structure
REQ-031 The state enumeration and the default widths SHALL live in shared package boot_pkg.
REQ-032 The RELEASE_DELAY counter SHALL be one sub-module, release_timer (load, count down, expire pulse).

Verification
REQ-033 Reset then start, 3 words 0x20080005, 0x20090007, 0x01095020 (last on the third) -> imem writes at addr 0,1,2; core_reset_n rises 4 cycles after the third write; done=1; word_count=3.
REQ-034 ld_valid toggled 1/0 each cycle during LOAD -> writes occur only on accepted cycles and addresses stay contiguous.
REQ-035 256 words with ld_last=0 -> 256 writes; ERROR state; err_overflow=1; core_reset_n=0.
REQ-036 reset asserted mid-LOAD after 2 words -> outputs take reset values at once; a fresh start reloads from addr 0.
REQ-037 start pulsed in RUN -> core_reset_n=0 next cycle; a new load overwrites from addr 0.
REQ-038 With BOOT_CHECKSUM_EN, words 0x1, 0x2, 0x4 and chk_expected=0x7 -> chk_ok=1 and RUN is reached; with chk_expected=0x6 -> ERROR and core_reset_n stays 0.
